// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types and sizing helpers for the parallel-to-serial gearbox.
//   bit_order_e : which end of the word leaves first
//   beats()     : beats per word for an N-bit word split into W-bit beats
//   cnt_width() : width of a counter that indexes those beats (min 1 bit)
package p2s_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  function automatic int unsigned beats(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/p2s_gearbox.sv
// p2s_gearbox: parallel-to-serial gearbox with a one-word holding buffer.
// N-bit words accepted on the parallel valid/ready port are emitted as
// N/W beats of W bits on the serial valid/ready port. The holding buffer
// lets the next word be accepted while the current one shifts out, so
// consecutive words stream with no idle cycle.
//   clk     : clock, all state updates on posedge
//   rst     : asynchronous, active-high reset
//   p_valid : parallel word offered
//   p_data  : parallel word (N bits)
//   p_ready : block can accept a word this cycle
//   s_ready : sink accepts a beat this cycle
//   s_valid : beat on s_data is valid
//   s_data  : current serial beat (W bits)
//   s_last  : current beat is the final beat of its word
module p2s_gearbox #(
  parameter int unsigned N         = 32,
  parameter int unsigned W         = 4,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p_valid,
  input  logic [N-1:0] p_data,
  output logic         p_ready,
  input  logic         s_ready,
  output logic         s_valid,
  output logic [W-1:0] s_data,
  output logic         s_last
);
  import p2s_pkg::*;

  localparam int unsigned K  = beats(N, W);
  localparam int unsigned CW = cnt_width(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST != 0);

  if ((N % W) != 0 || W > N) begin : g_bad_params
    $error("p2s_gearbox: N must be a multiple of W and W <= N");
  end

  logic [N-1:0]  sh;
  logic [N-1:0]  hold;
  logic          sh_valid;
  logic          hold_valid;
  logic [CW-1:0] cnt;

  logic          p_fire;
  logic          s_fire;
  logic          finish;
  logic [N-1:0]  sh_shifted;

  always_comb begin
    s_valid = sh_valid;
    p_ready = !hold_valid;
    s_last  = sh_valid && (cnt == CNT_LAST);
    s_data  = (ORDER == p2s_pkg::MSB_FIRST) ? sh[N-1 -: W] : sh[W-1:0];
  end

  always_comb begin
    p_fire     = p_valid && p_ready;
    s_fire     = s_valid && s_ready;
    // An idle shifter counts as a completed word so it can be loaded directly.
    finish     = (s_fire && s_last) || !sh_valid;
    sh_shifted = (ORDER == p2s_pkg::MSB_FIRST) ? (sh << W) : (sh >> W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh         <= '0;
      hold       <= '0;
      sh_valid   <= 1'b0;
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else if (finish) begin
      cnt <= '0;
      if (hold_valid) begin
        // p_ready is low here, so no new word can arrive this cycle.
        sh         <= hold;
        hold_valid <= 1'b0;
        sh_valid   <= 1'b1;
      end else if (p_fire) begin
        sh       <= p_data;
        sh_valid <= 1'b1;
      end else begin
        sh_valid <= 1'b0;
      end
    end else begin
      if (s_fire) begin
        sh  <= sh_shifted;
        cnt <= cnt + 1'b1;
      end
      if (p_fire) begin
        hold       <= p_data;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p2s_gearbox.sv
// tb_p2s_gearbox: randomized and directed bench for p2s_gearbox covering
// LSB-first (N=8,W=2), MSB-first (N=8,W=2) and degenerate K=1 (N=W=8).
// The reference model tracks words held by the block and a queue of the
// beats they must produce, derived arithmetically from each accepted word.
module tb_p2s_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       pv  = 1'b0;
  logic       sr  = 1'b0;
  logic [7:0] pd  = '0;
  int         cfg = 0;

  logic       pv0, pv1, pv2, sr0, sr1, sr2;
  logic       pr0, pr1, pr2, sv0, sv1, sv2, sl0, sl1, sl2;
  logic [1:0] sd0, sd1;
  logic [7:0] sd2;

  assign pv0 = pv && (cfg == 0);
  assign pv1 = pv && (cfg == 1);
  assign pv2 = pv && (cfg == 2);
  assign sr0 = sr && (cfg == 0);
  assign sr1 = sr && (cfg == 1);
  assign sr2 = sr && (cfg == 2);

  p2s_gearbox #(.N(8), .W(2), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .p_valid(pv0), .p_data(pd), .p_ready(pr0),
    .s_ready(sr0), .s_valid(sv0), .s_data(sd0), .s_last(sl0));

  p2s_gearbox #(.N(8), .W(2), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .p_valid(pv1), .p_data(pd), .p_ready(pr1),
    .s_ready(sr1), .s_valid(sv1), .s_data(sd1), .s_last(sl1));

  p2s_gearbox #(.N(8), .W(8), .MSB_FIRST(0)) dut_k1 (
    .clk(clk), .rst(rst), .p_valid(pv2), .p_data(pd), .p_ready(pr2),
    .s_ready(sr2), .s_valid(sv2), .s_data(sd2), .s_last(sl2));

  logic       cur_pr, cur_sv, cur_sl;
  logic [7:0] cur_sd;

  always_comb begin
    cur_pr = pr0; cur_sv = sv0; cur_sl = sl0; cur_sd = {6'b0, sd0};
    if (cfg == 1) begin
      cur_pr = pr1; cur_sv = sv1; cur_sl = sl1; cur_sd = {6'b0, sd1};
    end else if (cfg == 2) begin
      cur_pr = pr2; cur_sv = sv2; cur_sl = sl2; cur_sd = sd2;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cfg=%0d t=%0t got=%0h exp=%0h", tag, cfg, $time, got, exp);
    end
  endtask

  // Reference model: beats still owed, and number of words inside the block.
  typedef struct {
    int unsigned data;
    bit          last;
  } beat_t;

  beat_t expq[$];
  int    occ = 0;
  int    kk  = 4;
  int    ww  = 2;
  bit    msb = 1'b0;

  task automatic set_cfg(input int c);
    cfg = c;
    kk  = (c == 2) ? 1 : 4;
    ww  = (c == 2) ? 8 : 2;
    msb = (c == 1);
  endtask

  task automatic push_word(input logic [7:0] d);
    for (int i = 0; i < kk; i++) begin
      int    idx;
      beat_t b;
      idx    = msb ? (kk - 1 - i) : i;
      b.data = (int'(d) >> (ww * idx)) & ((1 << ww) - 1);
      b.last = (i == kk - 1);
      expq.push_back(b);
    end
  endtask

  // Called at a negedge: drive, check registered outputs, advance model.
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    bit p_fire, s_fire;
    pv = v; pd = d; sr = r;
    #1;
    check_eq("s_valid", cur_sv, (occ > 0));
    check_eq("p_ready", cur_pr, (occ < 2));
    check_eq("s_last", cur_sl, (occ > 0) ? expq[0].last : 1'b0);
    if (occ > 0) check_eq("s_data", cur_sd, expq[0].data);
    p_fire = v && (occ < 2);
    s_fire = r && (occ > 0);
    if (s_fire) begin
      beat_t b;
      b = expq.pop_front();
      if (b.last) occ--;
    end
    if (p_fire) begin
      push_word(d);
      occ++;
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] d, input bit r);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      done = (occ < 2);
      step(1'b1, d, r);
    end
    if (!done) check_eq("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && occ > 0; n++) step(1'b0, 8'h00, 1'b1);
    check_eq("drain_occ", occ, 0);
    step(1'b0, 8'h00, 1'b1);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_s_valid", cur_sv, 1'b0);
    check_eq("rst_s_last", cur_sl, 1'b0);
    check_eq("rst_s_data", cur_sd, 8'h00);
    check_eq("rst_p_ready", cur_pr, 1'b1);
    pv = 1'b1; pd = 8'hFF; sr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pv = 1'b0; sr = 1'b0; rst = 1'b0;
    expq.delete();
    occ = 0;
  endtask

  task automatic random_run(input int cycles);
    for (int n = 0; n < cycles; n++)
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
    drain();
  endtask

  initial begin
    @(negedge clk);

    // LSB-first N=8 W=2
    set_cfg(0);
    async_reset();
    step(1'b1, 8'hB4, 1'b1);
    drain();
    // back-to-back words
    step(1'b1, 8'hB4, 1'b1);
    send_word(8'h1E, 1'b1);
    drain();
    // backpressure with a third word offered while hold is full
    step(1'b1, 8'hB4, 1'b1);
    step(1'b1, 8'h1E, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    drain();
    // reset mid-word with hold full
    step(1'b1, 8'hB4, 1'b1);
    step(1'b1, 8'h1E, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    async_reset();
    step(1'b0, 8'h00, 1'b1);
    send_word(8'h3C, 1'b1);
    drain();
    random_run(300);

    // MSB-first N=8 W=2
    set_cfg(1);
    async_reset();
    step(1'b1, 8'hB4, 1'b1);
    drain();
    step(1'b1, 8'hB4, 1'b1);
    send_word(8'h1E, 1'b1);
    drain();
    random_run(300);

    // Degenerate K=1 (N=W=8)
    set_cfg(2);
    async_reset();
    step(1'b1, 8'h11, 1'b1);
    step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    drain();
    random_run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
